// File: rtl/tcp_perf_monitor_if.sv
// Tap bundle for the TCP application interface handshakes observed by
// tcp_perf_monitor. Every signal is a per-channel handshake strobe
// (valid & ready) or the payload field qualified by that strobe.
//   tx_meta_hs  [NUM_CH]        tx-metadata handshake
//   notif_hs    [NUM_CH]        notification handshake
//   tx_sts_hs   [NUM_CH]        tx-status handshake
//   tx_sts_err  [NUM_CH*3]      tx-status error code (0 = success)
//   tx_sts_len  [NUM_CH*LEN_W]  tx-status length
//   rd_pkg_hs   [NUM_CH]        read-package handshake
//   rd_pkg_len  [NUM_CH*LEN_W]  read-package length
// master: the network kernel side that drives the tap.
// slave : the monitor that only observes it.
interface tcp_perf_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int LEN_W  = 16
);
  logic [NUM_CH-1:0]       tx_meta_hs;
  logic [NUM_CH-1:0]       notif_hs;
  logic [NUM_CH-1:0]       tx_sts_hs;
  logic [NUM_CH*3-1:0]     tx_sts_err;
  logic [NUM_CH*LEN_W-1:0] tx_sts_len;
  logic [NUM_CH-1:0]       rd_pkg_hs;
  logic [NUM_CH*LEN_W-1:0] rd_pkg_len;

  modport master (
    output tx_meta_hs, notif_hs, tx_sts_hs, tx_sts_err, tx_sts_len,
           rd_pkg_hs, rd_pkg_len
  );

  modport slave (
    input  tx_meta_hs, notif_hs, tx_sts_hs, tx_sts_err, tx_sts_len,
           rd_pkg_hs, rd_pkg_len
  );
endinterface

// File: rtl/tcp_perf_monitor.sv
// Passive multi-channel TCP throughput / latency monitor.
// A measurement window opens on any tx-metadata or notification handshake
// (or a software start) and lasts max(cfg_win_cycles,1) cycles, the trigger
// cycle being window cycle 0. During the window, successful tx-status bytes
// and read-package bytes are summed per channel with saturation, and the
// window cycle at which each sum first reaches cfg_threshold is captured.
// When the window closes the sums are published as a coherent snapshot.
// Ports:
//   aclk, sys_reset      clock, asynchronous active-high reset
//   cfg_win_cycles       window length in cycles (0 behaves as 1)
//   cfg_threshold        per-channel byte threshold for crossing capture
//   cfg_sw_start         start a window from idle
//   cfg_abort            abandon the running window, snapshot untouched
//   tap                  observed handshakes (slave modport)
//   busy                 window running (through the publish cycle)
//   done                 one-cycle pulse coincident with a snapshot update
//   snap_cycles          length of the last completed window
//   snap_tx/rx_bytes     per-channel byte sums, CNT_W each
//   snap_tx/rx_cross     per-channel crossing cycle, all-ones if none
//   snap_valid           at least one window has completed
module tcp_perf_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 64,
  parameter int LEN_W  = 16,
  parameter int WIN_W  = 32
) (
  input  logic                    aclk,
  input  logic                    sys_reset,
  input  logic [WIN_W-1:0]        cfg_win_cycles,
  input  logic [CNT_W-1:0]        cfg_threshold,
  input  logic                    cfg_sw_start,
  input  logic                    cfg_abort,
  tcp_perf_monitor_if.slave       tap,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        snap_cycles,
  output logic [NUM_CH*CNT_W-1:0] snap_tx_bytes,
  output logic [NUM_CH*CNT_W-1:0] snap_rx_bytes,
  output logic [NUM_CH*CNT_W-1:0] snap_tx_cross,
  output logic [NUM_CH*CNT_W-1:0] snap_rx_cross,
  output logic                    snap_valid
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef logic [NUM_CH-1:0][CNT_W-1:0] cnt_arr_t;

  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Zero-extend the length and add; any carry out pins the sum at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                               input logic [LEN_W-1:0] len);
    logic [CNT_W:0] sum;
    sum = {1'b0, acc} + (CNT_W+1)'(len);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  state_t            state, state_nxt;
  logic [WIN_W-1:0]  wc, wc_nxt, wc_cur, win_last;
  cnt_arr_t          live_tx, live_rx, tx_cross, rx_cross;
  cnt_arr_t          tx_post, rx_post, tx_cross_upd, rx_cross_upd;
  logic [NUM_CH-1:0] tx_hit, rx_hit, tx_hit_upd, rx_hit_upd;
  logic              trigger, accumulate, clear_live, load_snap;

  assign trigger  = (|tap.tx_meta_hs) | (|tap.notif_hs) | cfg_sw_start;
  assign win_last = (cfg_win_cycles == '0) ? '0 : cfg_win_cycles - WIN_ONE;
  // The trigger cycle is window cycle 0 even though the FSM is still idle.
  assign wc_cur   = (state == S_RUN) ? wc : '0;

  // Per-channel post-add values and crossing candidates for this cycle.
  // The hit flags make crossing capture write-once without reserving the
  // all-ones value of the cross register as a marker.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      tx_post[c]      = live_tx[c];
      tx_cross_upd[c] = tx_cross[c];
      tx_hit_upd[c]   = tx_hit[c];
      if (tap.tx_sts_hs[c] && (tap.tx_sts_err[c*3 +: 3] == 3'd0)) begin
        tx_post[c] = sat_add(live_tx[c], tap.tx_sts_len[c*LEN_W +: LEN_W]);
        if (!tx_hit[c] && (tx_post[c] >= cfg_threshold)) begin
          tx_hit_upd[c]   = 1'b1;
          tx_cross_upd[c] = CNT_W'(wc_cur);
        end
      end
      rx_post[c]      = live_rx[c];
      rx_cross_upd[c] = rx_cross[c];
      rx_hit_upd[c]   = rx_hit[c];
      if (tap.rd_pkg_hs[c]) begin
        rx_post[c] = sat_add(live_rx[c], tap.rd_pkg_len[c*LEN_W +: LEN_W]);
        if (!rx_hit[c] && (rx_post[c] >= cfg_threshold)) begin
          rx_hit_upd[c]   = 1'b1;
          rx_cross_upd[c] = CNT_W'(wc_cur);
        end
      end
    end
  end

  // Next-state logic. The snapshot is loaded on the edge that ends the
  // final window cycle, so done and the new snapshot are visible together
  // during the DONE cycle; the live counters are cleared on that same edge.
  always_comb begin
    state_nxt  = state;
    wc_nxt     = wc;
    accumulate = 1'b0;
    clear_live = 1'b0;
    load_snap  = 1'b0;
    case (state)
      S_IDLE: begin
        if (trigger) begin
          accumulate = 1'b1;
          if (wc_cur == win_last) begin
            load_snap  = 1'b1;
            clear_live = 1'b1;
            wc_nxt     = '0;
            state_nxt  = S_DONE;
          end else begin
            wc_nxt    = wc_cur + WIN_ONE;
            state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (cfg_abort) begin
          clear_live = 1'b1;
          wc_nxt     = '0;
          state_nxt  = S_IDLE;
        end else begin
          accumulate = 1'b1;
          if (wc_cur == win_last) begin
            load_snap  = 1'b1;
            clear_live = 1'b1;
            wc_nxt     = '0;
            state_nxt  = S_DONE;
          end else begin
            wc_nxt = wc_cur + WIN_ONE;
          end
        end
      end
      S_DONE: begin
        clear_live = 1'b1;
        wc_nxt     = '0;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge sys_reset) begin
    if (sys_reset) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_ff @(posedge aclk or posedge sys_reset) begin
    if (sys_reset) begin
      wc            <= '0;
      live_tx       <= '0;
      live_rx       <= '0;
      tx_cross      <= '1;
      rx_cross      <= '1;
      tx_hit        <= '0;
      rx_hit        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      snap_valid    <= 1'b0;
      snap_cycles   <= '0;
      snap_tx_bytes <= '0;
      snap_rx_bytes <= '0;
      snap_tx_cross <= '1;
      snap_rx_cross <= '1;
    end else begin
      wc   <= wc_nxt;
      busy <= (state_nxt != S_IDLE);
      done <= load_snap;
      if (load_snap) begin
        snap_valid    <= 1'b1;
        snap_cycles   <= CNT_W'(wc_cur) + CNT_ONE;
        snap_tx_bytes <= tx_post;
        snap_rx_bytes <= rx_post;
        snap_tx_cross <= tx_cross_upd;
        snap_rx_cross <= rx_cross_upd;
      end
      if (clear_live) begin
        live_tx  <= '0;
        live_rx  <= '0;
        tx_cross <= '1;
        rx_cross <= '1;
        tx_hit   <= '0;
        rx_hit   <= '0;
      end else if (accumulate) begin
        live_tx  <= tx_post;
        live_rx  <= rx_post;
        tx_cross <= tx_cross_upd;
        rx_cross <= rx_cross_upd;
        tx_hit   <= tx_hit_upd;
        rx_hit   <= rx_hit_upd;
      end
    end
  end

endmodule

// File: tb/tb_tcp_perf_monitor.sv
// Self-checking bench for tcp_perf_monitor: directed windows, randomized
// windows against a sum/first-crossing reference model, abort, back-to-back
// windows, zero-length window, saturation (20-bit instance) and reset.
module tb_tcp_perf_monitor;
  localparam int NC   = 4;
  localparam int CW   = 64;
  localparam int LW   = 16;
  localparam int WW   = 32;
  localparam int SCW  = 20;
  localparam int MAXC = 64;

  logic aclk = 1'b0;
  logic sys_reset;
  always #5 aclk = ~aclk;

  logic [WW-1:0]    cfg_win_cycles;
  logic [CW-1:0]    cfg_threshold;
  logic             cfg_sw_start, cfg_abort;
  logic             busy, done, snap_valid;
  logic [CW-1:0]    snap_cycles;
  logic [NC*CW-1:0] snap_tx_bytes, snap_rx_bytes, snap_tx_cross, snap_rx_cross;

  tcp_perf_monitor_if #(.NUM_CH(NC), .LEN_W(LW)) tap ();

  tcp_perf_monitor #(.NUM_CH(NC), .CNT_W(CW), .LEN_W(LW), .WIN_W(WW)) dut (
    .aclk(aclk), .sys_reset(sys_reset), .cfg_win_cycles(cfg_win_cycles),
    .cfg_threshold(cfg_threshold), .cfg_sw_start(cfg_sw_start), .cfg_abort(cfg_abort),
    .tap(tap), .busy(busy), .done(done), .snap_cycles(snap_cycles),
    .snap_tx_bytes(snap_tx_bytes), .snap_rx_bytes(snap_rx_bytes),
    .snap_tx_cross(snap_tx_cross), .snap_rx_cross(snap_rx_cross), .snap_valid(snap_valid)
  );

  logic [WW-1:0]     s_win;
  logic [SCW-1:0]    s_thr;
  logic              s_sw_start, s_abort;
  logic              s_busy, s_done, s_snap_valid;
  logic [SCW-1:0]    s_snap_cycles;
  logic [NC*SCW-1:0] s_snap_tx, s_snap_rx, s_snap_tx_cross, s_snap_rx_cross;

  tcp_perf_monitor_if #(.NUM_CH(NC), .LEN_W(LW)) tap_s ();

  tcp_perf_monitor #(.NUM_CH(NC), .CNT_W(SCW), .LEN_W(LW), .WIN_W(WW)) dut_sat (
    .aclk(aclk), .sys_reset(sys_reset), .cfg_win_cycles(s_win),
    .cfg_threshold(s_thr), .cfg_sw_start(s_sw_start), .cfg_abort(s_abort),
    .tap(tap_s), .busy(s_busy), .done(s_done), .snap_cycles(s_snap_cycles),
    .snap_tx_bytes(s_snap_tx), .snap_rx_bytes(s_snap_rx),
    .snap_tx_cross(s_snap_tx_cross), .snap_rx_cross(s_snap_rx_cross), .snap_valid(s_snap_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Per-cycle stimulus pattern for one window (index = window cycle).
  logic [NC-1:0]    p_tx_hs  [MAXC];
  logic [NC*3-1:0]  p_err    [MAXC];
  logic [NC*LW-1:0] p_tx_len [MAXC];
  logic [NC-1:0]    p_rd_hs  [MAXC];
  logic [NC*LW-1:0] p_rd_len [MAXC];
  logic             p_abort  [MAXC];

  // Reference model: byte sums and first window cycle reaching the threshold.
  logic [CW-1:0] m_tx [NC], m_rx [NC], m_txc [NC], m_rxc [NC];
  bit            m_txx [NC], m_rxx [NC];
  // Last snapshot the DUT is expected to hold.
  logic [CW-1:0] k_tx [NC], k_rx [NC], k_txc [NC], k_rxc [NC];
  logic [CW-1:0] k_cycles;
  logic [CW-1:0] ones = '1;

  task automatic idle_inputs();
    tap.tx_meta_hs = '0; tap.notif_hs = '0; tap.tx_sts_hs = '0; tap.tx_sts_err = '0;
    tap.tx_sts_len = '0; tap.rd_pkg_hs = '0; tap.rd_pkg_len = '0;
    cfg_sw_start = 1'b0; cfg_abort = 1'b0;
  endtask

  task automatic s_idle();
    tap_s.tx_meta_hs = '0; tap_s.notif_hs = '0; tap_s.tx_sts_hs = '0; tap_s.tx_sts_err = '0;
    tap_s.tx_sts_len = '0; tap_s.rd_pkg_hs = '0; tap_s.rd_pkg_len = '0;
    s_sw_start = 1'b0; s_abort = 1'b0;
  endtask

  task automatic clear_pattern();
    for (int k = 0; k < MAXC; k++) begin
      p_tx_hs[k] = '0; p_err[k] = '0; p_tx_len[k] = '0;
      p_rd_hs[k] = '0; p_rd_len[k] = '0; p_abort[k] = 1'b0;
    end
  endtask

  task automatic random_pattern(input int n);
    for (int k = 0; k < n; k++) begin
      p_tx_hs[k]  = NC'($urandom);
      p_rd_hs[k]  = NC'($urandom);
      p_tx_len[k] = {$urandom, $urandom};
      p_rd_len[k] = {$urandom, $urandom};
      p_abort[k]  = 1'b0;
      for (int c = 0; c < NC; c++)
        p_err[k][c*3 +: 3] = ($urandom_range(1, 0) == 0) ? 3'd0 : 3'($urandom_range(7, 1));
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NC; c++) begin
      m_tx[c] = '0; m_rx[c] = '0; m_txc[c] = '1; m_rxc[c] = '1;
      m_txx[c] = 1'b0; m_rxx[c] = 1'b0;
    end
  endtask

  task automatic commit(input int n);
    for (int c = 0; c < NC; c++) begin
      k_tx[c] = m_tx[c]; k_rx[c] = m_rx[c]; k_txc[c] = m_txc[c]; k_rxc[c] = m_rxc[c];
    end
    k_cycles = CW'(n);
  endtask

  // Plays n window cycles (trigger in cycle 0: 0=meta, 1=notif, 2=sw start),
  // updating the model, and returns at the negedge of the cycle after.
  task automatic play(input int n, input int trig);
    for (int k = 0; k < n; k++) begin
      @(negedge aclk);
      if (k == 0) begin
        tap.tx_meta_hs = (trig == 0) ? NC'(1 << $urandom_range(NC-1, 0)) : '0;
        tap.notif_hs   = (trig == 1) ? NC'(1 << $urandom_range(NC-1, 0)) : '0;
        cfg_sw_start   = (trig == 2);
      end else begin
        tap.tx_meta_hs = NC'($urandom);
        tap.notif_hs   = NC'($urandom);
        cfg_sw_start   = 1'($urandom);
      end
      tap.tx_sts_hs = p_tx_hs[k]; tap.tx_sts_err = p_err[k]; tap.tx_sts_len = p_tx_len[k];
      tap.rd_pkg_hs = p_rd_hs[k]; tap.rd_pkg_len = p_rd_len[k]; cfg_abort = p_abort[k];
      for (int c = 0; c < NC; c++) begin
        if (p_tx_hs[k][c] && p_err[k][c*3 +: 3] == 3'd0) begin
          m_tx[c] = m_tx[c] + CW'(p_tx_len[k][c*LW +: LW]);
          if (!m_txx[c] && m_tx[c] >= cfg_threshold) begin m_txx[c] = 1'b1; m_txc[c] = CW'(k); end
        end
        if (p_rd_hs[k][c]) begin
          m_rx[c] = m_rx[c] + CW'(p_rd_len[k][c*LW +: LW]);
          if (!m_rxx[c] && m_rx[c] >= cfg_threshold) begin m_rxx[c] = 1'b1; m_rxc[c] = CW'(k); end
        end
      end
    end
    @(negedge aclk);
    idle_inputs();
  endtask

  task automatic test_reset();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (snap_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", snap_valid); end
    n_checks++; if (snap_cycles !== '0) begin n_fail++; $display("FAIL reset_cycles: got %0d expected 0", snap_cycles); end
    n_checks++; if (snap_tx_bytes !== '0 || snap_rx_bytes !== '0) begin
      n_fail++; $display("FAIL reset_bytes: got tx %0h rx %0h expected 0", snap_tx_bytes, snap_rx_bytes); end
    n_checks++; if (snap_tx_cross !== {NC*CW{1'b1}} || snap_rx_cross !== {NC*CW{1'b1}}) begin
      n_fail++; $display("FAIL reset_cross: got tx %0h rx %0h expected all-ones", snap_tx_cross, snap_rx_cross); end
  endtask

  task automatic test_directed_tx();
    clear_pattern(); model_clear();
    for (int i = 0; i < 3; i++) begin
      int k;
      k = (i == 0) ? 0 : (i == 1) ? 4 : 9;
      p_tx_hs[k] = 4'b0001; p_tx_len[k][15:0] = 16'd1000;
    end
    cfg_win_cycles = 10; cfg_threshold = 1500;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dir_busy_idle: got %b expected 0", busy); end
    play(10, 0);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL dir_done: got %b expected 1", done); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL dir_busy_done: got %b expected 1", busy); end
    n_checks++; if (snap_cycles !== 64'd10) begin n_fail++; $display("FAIL dir_cycles: got %0d expected 10", snap_cycles); end
    n_checks++; if (snap_tx_bytes[0 +: CW] !== 64'd3000) begin
      n_fail++; $display("FAIL dir_tx0: got %0d expected 3000", snap_tx_bytes[0 +: CW]); end
    n_checks++; if (snap_tx_cross[0 +: CW] !== 64'd4) begin
      n_fail++; $display("FAIL dir_cross0: got %0d expected 4", snap_tx_cross[0 +: CW]); end
    for (int c = 1; c < NC; c++) begin
      n_checks++; if (snap_tx_cross[c*CW +: CW] !== ones) begin
        n_fail++; $display("FAIL dir_cross%0d: got %0h expected all-ones", c, snap_tx_cross[c*CW +: CW]); end
    end
    n_checks++; if (snap_valid !== 1'b1) begin n_fail++; $display("FAIL dir_valid: got %b expected 1", snap_valid); end
    @(negedge aclk);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL dir_after: got done %b busy %b expected 0 0", done, busy); end
    commit(10);
  endtask

  task automatic test_err_rx();
    clear_pattern(); model_clear();
    for (int k = 0; k < 10; k++) begin
      p_tx_hs[k] = 4'b0001; p_err[k][2:0] = 3'b001; p_tx_len[k][15:0] = 16'd500;
      if (k < 8) begin p_rd_hs[k] = 4'b1111; p_rd_len[k] = {4{16'd64}}; end
    end
    cfg_win_cycles = 10; cfg_threshold = '1;
    play(10, 0);
    n_checks++; if (snap_tx_bytes[0 +: CW] !== 64'd0) begin
      n_fail++; $display("FAIL err_tx0: got %0d expected 0", snap_tx_bytes[0 +: CW]); end
    for (int c = 0; c < NC; c++) begin
      n_checks++; if (snap_rx_bytes[c*CW +: CW] !== 64'd512) begin
        n_fail++; $display("FAIL err_rx%0d: got %0d expected 512", c, snap_rx_bytes[c*CW +: CW]); end
    end
    commit(10);
  endtask

  task automatic test_win_zero();
    clear_pattern(); model_clear();
    p_tx_hs[0] = 4'b0010; p_tx_len[0][31:16] = 16'd7;
    cfg_win_cycles = 0; cfg_threshold = 0;
    play(1, 2);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL w0_done: got %b expected 1", done); end
    n_checks++; if (snap_cycles !== 64'd1) begin n_fail++; $display("FAIL w0_cycles: got %0d expected 1", snap_cycles); end
    n_checks++; if (snap_tx_bytes[CW +: CW] !== 64'd7) begin
      n_fail++; $display("FAIL w0_tx1: got %0d expected 7", snap_tx_bytes[CW +: CW]); end
    n_checks++; if (snap_tx_cross[CW +: CW] !== 64'd0) begin
      n_fail++; $display("FAIL w0_txcross1: got %0h expected 0", snap_tx_cross[CW +: CW]); end
    n_checks++; if (snap_tx_cross[0 +: CW] !== ones || snap_rx_cross[CW +: CW] !== ones) begin
      n_fail++; $display("FAIL w0_nocross: got tx0 %0h rx1 %0h expected all-ones",
                         snap_tx_cross[0 +: CW], snap_rx_cross[CW +: CW]); end
    commit(1);
  endtask

  task automatic test_random();
    for (int w = 0; w < 8; w++) begin
      int n;
      cfg_win_cycles = WW'($urandom_range(16, 0));
      n = (cfg_win_cycles == 0) ? 1 : int'(cfg_win_cycles);
      cfg_threshold = ($urandom_range(3, 0) == 0) ? '0 : CW'($urandom_range(200000, 0));
      clear_pattern(); random_pattern(n); model_clear();
      play(n, int'($urandom_range(2, 0)));
      n_checks++; if (done !== 1'b1 || snap_cycles !== CW'(n)) begin
        n_fail++; $display("FAIL rand_done w%0d: got done %b cycles %0d expected 1 %0d", w, done, snap_cycles, n); end
      for (int c = 0; c < NC; c++) begin
        n_checks++; if (snap_tx_bytes[c*CW +: CW] !== m_tx[c]) begin
          n_fail++; $display("FAIL rand_tx w%0d c%0d: got %0d expected %0d", w, c, snap_tx_bytes[c*CW +: CW], m_tx[c]); end
        n_checks++; if (snap_rx_bytes[c*CW +: CW] !== m_rx[c]) begin
          n_fail++; $display("FAIL rand_rx w%0d c%0d: got %0d expected %0d", w, c, snap_rx_bytes[c*CW +: CW], m_rx[c]); end
        n_checks++; if (snap_tx_cross[c*CW +: CW] !== m_txc[c]) begin
          n_fail++; $display("FAIL rand_txc w%0d c%0d: got %0h expected %0h", w, c, snap_tx_cross[c*CW +: CW], m_txc[c]); end
        n_checks++; if (snap_rx_cross[c*CW +: CW] !== m_rxc[c]) begin
          n_fail++; $display("FAIL rand_rxc w%0d c%0d: got %0h expected %0h", w, c, snap_rx_cross[c*CW +: CW], m_rxc[c]); end
      end
      commit(n);
    end
  endtask

  task automatic test_abort();
    bit seen;
    cfg_win_cycles = 6; cfg_threshold = CW'($urandom_range(100000, 0));
    clear_pattern(); random_pattern(6); model_clear();
    p_abort[5] = 1'b1;
    play(6, 0);
    seen = done;
    @(negedge aclk);
    seen = seen | done;
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_done: got pulse expected none"); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_checks++; if (snap_cycles !== k_cycles) begin
      n_fail++; $display("FAIL abort_cycles: got %0d expected %0d", snap_cycles, k_cycles); end
    for (int c = 0; c < NC; c++) begin
      n_checks++; if (snap_tx_bytes[c*CW +: CW] !== k_tx[c] || snap_rx_bytes[c*CW +: CW] !== k_rx[c] ||
                      snap_tx_cross[c*CW +: CW] !== k_txc[c] || snap_rx_cross[c*CW +: CW] !== k_rxc[c]) begin
        n_fail++; $display("FAIL abort_snap c%0d: got tx %0d rx %0d expected tx %0d rx %0d", c,
                           snap_tx_bytes[c*CW +: CW], snap_rx_bytes[c*CW +: CW], k_tx[c], k_rx[c]); end
    end
    cfg_win_cycles = 5;
    clear_pattern(); random_pattern(5); model_clear();
    play(5, 1);
    for (int c = 0; c < NC; c++) begin
      n_checks++; if (snap_tx_bytes[c*CW +: CW] !== m_tx[c] || snap_rx_bytes[c*CW +: CW] !== m_rx[c]) begin
        n_fail++; $display("FAIL abort_next c%0d: got tx %0d rx %0d expected tx %0d rx %0d", c,
                           snap_tx_bytes[c*CW +: CW], snap_rx_bytes[c*CW +: CW], m_tx[c], m_rx[c]); end
    end
    commit(5);
  endtask

  task automatic test_back_to_back();
    cfg_win_cycles = 5; cfg_threshold = CW'($urandom_range(60000, 0));
    clear_pattern(); random_pattern(5); model_clear();
    play(5, 1);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done1: got %b expected 1", done); end
    // Events during the publish cycle must not reach the next window.
    tap.rd_pkg_hs = 4'b1111; tap.rd_pkg_len = {4{16'd100}};
    tap.tx_sts_hs = 4'b1111; tap.tx_sts_len = {4{16'd100}};
    clear_pattern(); random_pattern(5); model_clear();
    play(5, 0);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done2: got %b expected 1", done); end
    for (int c = 0; c < NC; c++) begin
      n_checks++; if (snap_tx_bytes[c*CW +: CW] !== m_tx[c] || snap_rx_bytes[c*CW +: CW] !== m_rx[c]) begin
        n_fail++; $display("FAIL b2b_bytes c%0d: got tx %0d rx %0d expected tx %0d rx %0d", c,
                           snap_tx_bytes[c*CW +: CW], snap_rx_bytes[c*CW +: CW], m_tx[c], m_rx[c]); end
    end
    commit(5);
  endtask

  task automatic test_saturation();
    longint unsigned acc, lim;
    longint unsigned xc;
    lim = (64'd1 << SCW) - 1; acc = 0; xc = lim;
    for (int k = 0; k < 30; k++) begin
      acc = (acc + 65535 > lim) ? lim : acc + 65535;
      if (xc == lim && acc >= lim) xc = longint'(k);
    end
    s_win = 30; s_thr = '1;
    for (int k = 0; k < 30; k++) begin
      @(negedge aclk);
      tap_s.tx_meta_hs = (k == 0) ? 4'b1000 : 4'b0000;
      tap_s.tx_sts_hs = 4'b1111; tap_s.tx_sts_len = {4{16'hFFFF}};
      tap_s.rd_pkg_hs = 4'b1111; tap_s.rd_pkg_len = {4{16'hFFFF}};
    end
    @(negedge aclk);
    s_idle();
    n_checks++; if (s_done !== 1'b1 || s_snap_valid !== 1'b1 || s_busy !== 1'b1 || s_snap_cycles !== SCW'(30)) begin
      n_fail++; $display("FAIL sat_done: got done %b valid %b busy %b cycles %0d expected 1 1 1 30",
                         s_done, s_snap_valid, s_busy, s_snap_cycles); end
    for (int c = 0; c < NC; c++) begin
      n_checks++; if (s_snap_tx[c*SCW +: SCW] !== SCW'(acc) || s_snap_rx[c*SCW +: SCW] !== SCW'(acc)) begin
        n_fail++; $display("FAIL sat_bytes c%0d: got tx %0h rx %0h expected %0h", c,
                           s_snap_tx[c*SCW +: SCW], s_snap_rx[c*SCW +: SCW], acc); end
      n_checks++; if (s_snap_tx_cross[c*SCW +: SCW] !== SCW'(xc) || s_snap_rx_cross[c*SCW +: SCW] !== SCW'(xc)) begin
        n_fail++; $display("FAIL sat_cross c%0d: got tx %0h rx %0h expected %0h", c,
                           s_snap_tx_cross[c*SCW +: SCW], s_snap_rx_cross[c*SCW +: SCW], xc); end
    end
  endtask

  task automatic test_reset_mid();
    cfg_win_cycles = 20; cfg_threshold = 0;
    @(negedge aclk);
    tap.tx_meta_hs = 4'b0001; tap.tx_sts_hs = 4'b1111; tap.tx_sts_len = {4{16'd50}};
    @(negedge aclk);
    tap.tx_meta_hs = '0;
    @(posedge aclk);
    #2 sys_reset = 1'b1;
    #1;
    test_reset();
    @(negedge aclk);
    idle_inputs();
    sys_reset = 1'b0;
  endtask

  initial begin
    sys_reset = 1'b1;
    idle_inputs(); s_idle();
    cfg_win_cycles = 10; cfg_threshold = '0; s_win = 1; s_thr = '0;
    repeat (3) @(negedge aclk);
    test_reset();
    sys_reset = 1'b0;
    @(negedge aclk);
    test_reset();
    test_directed_tx();
    test_err_rx();
    test_win_zero();
    test_random();
    test_abort();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
